// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register offsets on the CPU io_bus
// and the hex-digit to seven-segment lookup table.
package mmio_responder_pkg;

    localparam logic [7:0] IO_LED      = 8'h00;
    localparam logic [7:0] IO_IN_ST    = 8'h04;
    localparam logic [7:0] IO_IN_DATA  = 8'h08;
    localparam logic [7:0] IO_OUT_ST   = 8'h0C;
    localparam logic [7:0] IO_OUT_DATA = 8'h10;
    localparam int         IO_SEL_BIT  = 10;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/mmio_responder_debounce.sv
// Conditions one raw asynchronous input: 2-flop synchronizer, stability counter,
// and a one-cycle pulse on each debounced rising edge.
module mmio_responder_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int              CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       primed;
    logic             armed;
    logic             update;

    assign update = (sync2 != stable) && (cnt == CNT_LAST);
    assign level  = stable;

    // An input held high through reset must not look like a fresh press, so the
    // edge detector arms only after a genuine low has come through the synchronizer.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            primed <= 2'b00;
            armed  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            if (primed[1] && !sync2) begin
                armed <= 1'b1;
            end

            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync2;
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            pulse <= update && sync2 && armed;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder between the CPU io_bus and board pins: LED register, debounced
// switch input channel, seven-segment output channel and 8-digit display scan.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int SCAN_BITS = 17,
    parameter int NSW       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     io_addr,
    input  logic [31:0]     io_dout,
    input  logic            io_we,
    output logic [31:0]     io_din,
    input  logic [NSW-1:0]  sw,
    input  logic [1:0]      btn,
    output logic [NSW-1:0]  led,
    output logic [7:0]      an,
    output logic [6:0]      seg
);

    localparam int SCAN_W = SCAN_BITS + 3;

    logic [NSW-1:0]    sw_level;
    logic [NSW-1:0]    sw_pulse;
    logic [1:0]        btn_level;
    logic [1:0]        btn_pulse;

    logic              sel;
    logic [7:0]        offset;
    logic              wr_led;
    logic              wr_in_clr;
    logic              wr_out;

    logic              in_vld;
    logic [NSW-1:0]    sw_snap;
    logic [31:0]       seg_val;
    logic              out_rdy;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        scan_idx;
    logic [3:0]        nibble;

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        mmio_responder_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw[i]),
            .level (sw_level[i]),
            .pulse (sw_pulse[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        mmio_responder_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    assign sel       = io_addr[IO_SEL_BIT];
    assign offset    = io_addr[7:0];
    assign wr_led    = io_we && sel && (offset == IO_LED);
    assign wr_in_clr = io_we && sel && (offset == IO_IN_ST) && io_dout[0];
    assign wr_out    = io_we && sel && (offset == IO_OUT_DATA);

    // Button events take priority on the input side, CPU writes on the output side.
    always_ff @(posedge clk) begin
        if (rst) begin
            led      <= '0;
            in_vld   <= 1'b0;
            sw_snap  <= '0;
            seg_val  <= '0;
            out_rdy  <= 1'b1;
            scan_cnt <= '0;
        end else begin
            if (wr_led) begin
                led <= io_dout[NSW-1:0];
            end

            if (btn_pulse[0]) begin
                in_vld  <= 1'b1;
                sw_snap <= sw_level;
            end else if (wr_in_clr) begin
                in_vld <= 1'b0;
            end

            if (wr_out) begin
                seg_val <= io_dout;
                out_rdy <= 1'b0;
            end else if (btn_pulse[1]) begin
                out_rdy <= 1'b1;
            end

            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // NOTE: the default assignment before the case keeps this block purely
    // combinational; a path that leaves io_din unassigned would infer a latch.
    always_comb begin
        io_din = '0;
        if (sel) begin
            case (offset)
                IO_IN_ST:   io_din = {31'b0, in_vld};
                IO_IN_DATA: io_din = 32'(sw_snap);
                IO_OUT_ST:  io_din = {31'b0, out_rdy};
                default:    io_din = '0;
            endcase
        end
    end

    assign scan_idx = scan_cnt[SCAN_BITS +: 3];
    assign an       = ~(8'b0000_0001 << scan_idx);
    assign nibble   = seg_val[{scan_idx, 2'b00} +: 4];
    assign seg      = hex_to_seg(nibble);

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized scoreboard bench for mmio_responder against a cycle-level behavioural
// model of the bus registers, input conditioning and display scan.
module tb_mmio_responder;

    localparam int NSW = 16;
    localparam int DB  = 4;
    localparam int SB  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    io_addr;
    logic [31:0]    io_dout;
    logic           io_we;
    logic [31:0]    io_din;
    logic [NSW-1:0] sw;
    logic [1:0]     btn;
    logic [NSW-1:0] led;
    logic [7:0]     an;
    logic [6:0]     seg;

    always #5 clk = ~clk;

    mmio_responder #(.DB_CYCLES(DB), .SCAN_BITS(SB), .NSW(NSW)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .io_we   (io_we),
        .io_din  (io_din),
        .sw      (sw),
        .btn     (btn),
        .led     (led),
        .an      (an),
        .seg     (seg)
    );

    typedef enum int {K_DIN, K_LED, K_AN, K_SEG} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural reference model ----------------
    // Inputs are {btn[1], btn[0], sw}; a debounced bit flips once the raw samples
    // taken 2..DB+1 edges ago all disagree with it.
    logic [15:0] m_led;
    logic        m_in_vld;
    logic [15:0] m_snap;
    logic [31:0] m_seg;
    logic        m_rdy;
    int          m_scan;
    logic [17:0] hist [DB+2];
    logic [17:0] stab;
    logic [1:0]  pend;
    logic [1:0]  armed;
    int          n_since;

    task automatic model_step();
        logic [17:0] raw;
        logic [1:0]  new_pend;
        logic        wr;
        logic [7:0]  off;
        logic        steady;
        if (rst) begin
            m_led = '0; m_in_vld = 1'b0; m_snap = '0; m_seg = '0; m_rdy = 1'b1;
            m_scan = 0; stab = '0; pend = '0; armed = '0; n_since = 0;
            for (int k = 0; k < DB + 2; k++) hist[k] = '0;
        end else begin
            raw = {btn, sw};
            wr  = io_we && io_addr[10];
            off = io_addr[7:0];
            if (wr && off == 8'h00) m_led = io_dout[15:0];
            if (pend[0]) begin
                m_in_vld = 1'b1;
                m_snap   = stab[15:0];
            end else if (wr && off == 8'h04 && io_dout[0]) begin
                m_in_vld = 1'b0;
            end
            if (wr && off == 8'h10) begin
                m_seg = io_dout;
                m_rdy = 1'b0;
            end else if (pend[1]) begin
                m_rdy = 1'b1;
            end

            for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = raw;
            n_since++;
            new_pend = '0;
            for (int b = 0; b < 18; b++) begin
                steady = 1'b1;
                for (int k = 2; k <= DB + 1; k++) if (hist[k][b] == stab[b]) steady = 1'b0;
                if (steady) begin
                    stab[b] = ~stab[b];
                    if (b >= 16 && stab[b] && armed[b-16]) new_pend[b-16] = 1'b1;
                end
            end
            for (int i = 0; i < 2; i++) if (n_since >= 3 && !hist[2][16+i]) armed[i] = 1'b1;
            pend = new_pend;
            m_scan++;
        end
    endtask

    always @(posedge clk) model_step();

    function automatic logic [31:0] ref_din(input logic [31:0] a);
        if (!a[10]) return 32'h0;
        case (a[7:0])
            8'h04:   return {31'b0, m_in_vld};
            8'h08:   return {16'b0, m_snap};
            8'h0C:   return {31'b0, m_rdy};
            default: return 32'h0;
        endcase
    endfunction

    function automatic string lit_segments(input logic [3:0] n);
        case (n)
            4'h0: return "abcdef";   4'h1: return "bc";
            4'h2: return "abdeg";    4'h3: return "abcdg";
            4'h4: return "bcfg";     4'h5: return "acdfg";
            4'h6: return "acdefg";   4'h7: return "abc";
            4'h8: return "abcdefg";  4'h9: return "abcdfg";
            4'hA: return "abcefg";   4'hB: return "cdefg";
            4'hC: return "adef";     4'hD: return "bcdeg";
            4'hE: return "adefg";    default: return "aefg";
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        string       s;
        logic [6:0]  r;
        s = lit_segments(n);
        r = 7'h7F;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                K_DIN:   mon_act = io_din;
                K_LED:   mon_act = {16'b0, led};
                K_AN:    mon_act = {24'b0, an};
                default: mon_act = {25'b0, seg};
            endcase
            check(mon_e.name, mon_act, mon_e.exp);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input kind_t k, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc; e.kind = k; e.exp = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic push_disp();
        int idx;
        idx = (m_scan >> SB) % 8;
        push_exp(K_AN,  32'(8'hFF ^ (8'h01 << idx)), "scan_an");
        push_exp(K_SEG, 32'(ref_seg(m_seg[4*idx +: 4])), "scan_seg");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
        io_addr = a;
        io_we   = 1'b0;
        push_exp(K_DIN, v, nm);
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_addr = a;
        io_dout = d;
        io_we   = 1'b1;
        tick();
        io_we   = 1'b0;
    endtask

    task automatic wait_pend(input int i, input string nm);
        int n;
        n = 0;
        while (!pend[i] && n < 30) begin
            tick();
            n++;
        end
        if (!pend[i]) check(nm, 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         hold [2];
        logic [7:0] offs [6];
        logic [7:0] off;
        logic [31:0] a;

        rst = 1'b1; io_addr = '0; io_dout = '0; io_we = 1'b0; sw = '0; btn = '0;
        tick(2);
        rst = 1'b0;

        // reset state
        push_exp(K_LED, 32'h0,  "rst_led");
        push_exp(K_AN,  32'hFE, "rst_an");
        push_exp(K_SEG, 32'h40, "rst_seg");
        rd(32'h40C, 32'h1, "rst_out_rdy");
        rd(32'h404, 32'h0, "rst_in_vld");

        // LED register and address decode
        wr(32'h400, 32'h0000_A5A5);
        push_exp(K_LED, 32'hA5A5, "led_write");
        wr(32'h300, 32'h0000_FFFF);
        push_exp(K_LED, 32'hA5A5, "led_unselected");
        rd(32'h414, 32'h0, "unmapped_read");
        rd(32'h400, 32'h0, "write_only_read");

        // input channel, with cycle-exact timing of in_vld
        sw = 16'h1234;
        btn[0] = 1'b1;
        repeat (10) rd(32'h404, ref_din(32'h404), "in_vld_timing");
        btn[0] = 1'b0;
        rd(32'h404, 32'h1, "in_vld_set");
        rd(32'h408, 32'h1234, "in_data");
        sw = 16'h5678;
        tick(8);
        rd(32'h408, 32'h1234, "in_data_held");
        wr(32'h404, 32'h1);
        rd(32'h404, 32'h0, "in_vld_w1c");

        // bounce rejection
        repeat (5) begin
            btn[0] = 1'b1; tick(2);
            btn[0] = 1'b0; tick(2);
        end
        tick(8);
        rd(32'h404, 32'h0, "bounce_reject");

        // W1C in the same cycle as a confirm pulse: set wins
        btn[0] = 1'b1;
        wait_pend(0, "pend0_timeout");
        wr(32'h404, 32'h1);
        rd(32'h404, 32'h1, "w1c_vs_pulse");
        rd(32'h408, 32'h5678, "snap_on_collision");
        btn[0] = 1'b0;
        tick(8);

        // output channel and display scan
        wr(32'h410, 32'h89AB_CDEF);
        rd(32'h40C, 32'h0, "out_rdy_clr");
        repeat (32) begin
            push_disp();
            tick();
        end
        btn[1] = 1'b1;
        tick(10);
        rd(32'h40C, 32'h1, "out_rdy_ack");
        btn[1] = 1'b0;
        tick(8);
        btn[1] = 1'b1;
        wait_pend(1, "pend1_timeout");
        wr(32'h410, 32'h0000_00C3);
        rd(32'h40C, 32'h0, "out_write_vs_pulse");
        btn[1] = 1'b0;
        tick(8);

        // randomized traffic against the model
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        hold[0] = 3; hold[1] = 5;
        repeat (300) begin
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
            for (int i = 0; i < 2; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn[i]  = ~btn[i];
                    hold[i] = $urandom_range(1, 12);
                end
            end
            off = ($urandom_range(0, 7) == 0) ? 8'($urandom) : offs[$urandom_range(0, 5)];
            a = {21'b0, ($urandom_range(0, 5) != 0), 2'b00, off};
            io_addr = a;
            io_dout = $urandom;
            io_we   = ($urandom_range(0, 2) == 0);
            push_exp(K_DIN, ref_din(a), "rand_din");
            push_exp(K_LED, {16'b0, m_led}, "rand_led");
            push_disp();
            tick();
            io_we = 1'b0;
        end

        // reset in the middle of a confirm debounce with the button held
        btn = '0; sw = '0;
        tick(10);
        wr(32'h404, 32'h1);
        btn[0] = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        push_exp(K_LED, 32'h0,  "rst2_led");
        push_exp(K_AN,  32'hFE, "rst2_an");
        push_exp(K_SEG, 32'h40, "rst2_seg");
        rd(32'h40C, 32'h1, "rst2_out_rdy");
        tick(12);
        rd(32'h404, 32'h0, "rst_no_pulse");
        btn[0] = 1'b0;
        tick(10);
        btn[0] = 1'b1;
        tick(10);
        rd(32'h404, 32'h1, "post_rst_press");
        rd(32'h408, 32'h0, "post_rst_snap");

        tick(2);
        if (sb_q.size() != 0) check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
